// File: rtl/ma_threshold_detector.sv
// Hysteresis comparator with per-sample debounce on the moving-average stream.
// Produces a clean level, rise/fall pulses, a saturating rise counter and a re-timed sample/strobe.
module ma_threshold_detector #(
  parameter int DATA_W   = 10,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              strobe_in,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic              clr_cnt,
  output logic              level,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [CNT_W-1:0]  event_cnt,
  output logic [DATA_W-1:0] sample_out,
  output logic              strobe_out
);

  // State bit 1 doubles as the level (HIGH and PEND_LO).
  localparam logic [1:0] S_LOW     = 2'd0;
  localparam logic [1:0] S_PEND_HI = 2'd1;
  localparam logic [1:0] S_HIGH    = 2'd2;
  localparam logic [1:0] S_PEND_LO = 2'd3;

  localparam logic [4:0] DEB     = 5'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        r_state;
  logic [3:0]        r_run;
  logic              r_rise;
  logic              r_fall;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sample;
  logic              r_strobe;

  logic [1:0] w_state_nxt;
  logic [3:0] w_run_nxt;
  logic       w_rise;
  logic       w_fall;
  logic       w_above;
  logic       w_below;
  logic [4:0] w_run_inc;

  assign w_above   = (sample_in >= thr_hi);
  assign w_below   = (sample_in <= thr_lo);
  assign w_run_inc = {1'b0, r_run} + 5'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    if (strobe_in) begin
      case (r_state)
        S_LOW: begin
          if (w_above) begin
            if (DEB == 5'd1) begin
              w_state_nxt = S_HIGH;
              w_rise      = 1'b1;
            end else begin
              w_state_nxt = S_PEND_HI;
              w_run_nxt   = 4'd1;
            end
          end
        end
        S_PEND_HI: begin
          if (!w_above) begin
            w_state_nxt = S_LOW;
            w_run_nxt   = 4'd0;
          end else if (w_run_inc == DEB) begin
            w_state_nxt = S_HIGH;
            w_run_nxt   = 4'd0;
            w_rise      = 1'b1;
          end else begin
            w_run_nxt = w_run_inc[3:0];
          end
        end
        S_HIGH: begin
          if (w_below) begin
            if (DEB == 5'd1) begin
              w_state_nxt = S_LOW;
              w_fall      = 1'b1;
            end else begin
              w_state_nxt = S_PEND_LO;
              w_run_nxt   = 4'd1;
            end
          end
        end
        default: begin
          if (!w_below) begin
            w_state_nxt = S_HIGH;
            w_run_nxt   = 4'd0;
          end else if (w_run_inc == DEB) begin
            w_state_nxt = S_LOW;
            w_run_nxt   = 4'd0;
            w_fall      = 1'b1;
          end else begin
            w_run_nxt = w_run_inc[3:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_LOW;
      r_run    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
      r_sample <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_sample <= sample_in;
      r_strobe <= strobe_in;
      // A clear coinciding with a rise still counts that rise.
      if (clr_cnt)
        r_cnt <= w_rise ? CNT_W'(1) : '0;
      else if (w_rise && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign level      = r_state[1];
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign event_cnt  = r_cnt;
  assign sample_out = r_sample;
  assign strobe_out = r_strobe;

endmodule

// File: tb/tb_ma_threshold_detector.sv
// Directed bench for ma_threshold_detector: debounce, glitch rejection, hysteresis,
// counter saturation/clear and async reset mid-pending.
module tb_ma_threshold_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sample_in = '0;
  logic       strobe_in = 1'b0;
  logic [9:0] thr_hi = 10'd200;
  logic [9:0] thr_lo = 10'd100;
  logic       clr_cnt = 1'b0;
  logic       level, rise_pulse, fall_pulse, strobe_out;
  logic [7:0] event_cnt;
  logic [9:0] sample_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ma_threshold_detector #(.DATA_W(10), .DEBOUNCE(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .strobe_in(strobe_in),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clr_cnt(clr_cnt),
    .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_cnt(event_cnt), .sample_out(sample_out), .strobe_out(strobe_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n back-to-back strobes of value v; returns at the negedge after the last one was sampled
  task automatic burst(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_in = v;
      strobe_in = 1'b1;
    end
    @(negedge clk);
    strobe_in = 1'b0;
  endtask

  // single strobe preceded by at least one idle cycle
  task automatic send(input logic [9:0] v);
    @(negedge clk);
    burst(v, 1);
  endtask

  initial begin
    int rises;
    repeat (2) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_cnt", event_cnt, 0);
    chk("rst_pulses", {rise_pulse, fall_pulse, strobe_out}, 0);
    chk("rst_sample_out", sample_out, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_level", level, 0);

    // basic rise/fall with idle gaps
    send(0); send(0);
    send(255); send(255);
    chk("pend_level", level, 0);
    send(255);
    chk("rise_pulse", rise_pulse, 1);
    chk("rise_level", level, 1);
    chk("rise_cnt", event_cnt, 1);
    chk("rise_strobe_out", strobe_out, 1);
    chk("rise_sample_out", sample_out, 255);
    chk("rise_no_fall", fall_pulse, 0);
    @(negedge clk);
    chk("rise_one_cycle", rise_pulse, 0);
    send(255); send(0); send(0);
    chk("pend_lo_level", level, 1);
    chk("pend_lo_nofall", fall_pulse, 0);
    send(0);
    chk("fall_pulse", fall_pulse, 1);
    chk("fall_level", level, 0);

    // glitch rejection
    rises = 0;
    send(255); rises += rise_pulse;
    send(255); rises += rise_pulse;
    send(0);   rises += rise_pulse;
    send(255); rises += rise_pulse;
    send(255); rises += rise_pulse;
    chk("glitch_norise", rises, 0);
    chk("glitch_level", level, 0);
    send(255);
    chk("glitch_rise", rise_pulse, 1);
    chk("glitch_cnt", event_cnt, 2);

    // hysteresis, thr_lo inclusive
    for (int i = 0; i < 5; i++) send(150);
    chk("hyst_level", level, 1);
    send(100); send(100);
    chk("hyst_pend", level, 1);
    send(100);
    chk("hyst_fall", fall_pulse, 1);
    chk("hyst_level_lo", level, 0);

    // back-to-back strobes, 258 more rises -> 260 total, saturates at 255
    for (int i = 0; i < 258; i++) begin
      burst(255, 3);
      if (i == 0) begin
        chk("b2b_rise", rise_pulse, 1);
        chk("b2b_cnt", event_cnt, 3);
      end
      burst(0, 3);
      if (i == 0) chk("b2b_fall", fall_pulse, 1);
    end
    chk("sat_cnt", event_cnt, 255);
    chk("sat_level", level, 0);

    // clear together with a rise
    send(255); send(255);
    @(negedge clk);
    sample_in = 255; strobe_in = 1'b1; clr_cnt = 1'b1;
    @(negedge clk);
    strobe_in = 1'b0; clr_cnt = 1'b0;
    chk("clr_rise_pulse", rise_pulse, 1);
    chk("clr_rise_cnt", event_cnt, 1);

    // async reset mid-PEND_HI
    burst(0, 3);
    chk("pre_rst_level", level, 0);
    send(255); send(255);
    rst = 1'b1;
    #1;
    chk("arst_cnt", event_cnt, 0);
    chk("arst_strobe_out", strobe_out, 0);
    chk("arst_sample_out", sample_out, 0);
    @(negedge clk);
    rst = 1'b0;
    send(255); send(255);
    chk("post_rst_pend", level, 0);
    chk("post_rst_norise", rise_pulse, 0);
    send(255);
    chk("post_rst_rise", rise_pulse, 1);
    chk("post_rst_cnt", event_cnt, 1);

    // clear alone
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_alone", event_cnt, 0);
    chk("clr_level", level, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ma_threshold_detector.md
Name: ma_threshold_detector

Overview:
Downstream consumer of the moving-average filter output stream: a 10-bit sample with a one-cycle strobe per sample. Applies a hysteresis comparator with per-sample debounce, producing a clean level, one-cycle rise/fall event pulses, and a saturating rise-event counter. It also re-times the sample/strobe pair by one cycle so that any later stage sees data aligned with the detector outputs.

Parameters:
DATA_W, 10, sample width; matches the filter output width.
DEBOUNCE, 3, consecutive qualifying strobed samples required to change level; legal range 1..15.
CNT_W, 8, width of the rise-event counter.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  asynchronous, active-high reset.
sample_in  input  DATA_W  filtered sample (filter data_out).
strobe_in  input  1  sample valid; single-cycle pulse per sample.
thr_hi  input  DATA_W  upper threshold; unsigned.
thr_lo  input  DATA_W  lower threshold; unsigned.
clr_cnt  input  1  synchronous clear of event_cnt.
level  output  1  debounced detector state; 1 = HIGH.
rise_pulse  output  1  one-cycle pulse on LOW->HIGH.
fall_pulse  output  1  one-cycle pulse on HIGH->LOW.
event_cnt  output  CNT_W  number of rise events; saturating.
sample_out  output  DATA_W  sample_in registered by one cycle.
strobe_out  output  1  strobe_in registered by one cycle.

Behaviour:
- Reset (async, rst=1): state=LOW, run counter=0, level=0, rise_pulse=0, fall_pulse=0, event_cnt=0, sample_out=0, strobe_out=0. Reset asserted mid-pending discards the pending run.
- Comparisons are unsigned.
  - above = (sample_in >= thr_hi).
  - below = (sample_in <= thr_lo).
  - Both are evaluated only in cycles where strobe_in=1. Non-strobe cycles change nothing except the pulses, which are cleared.
- FSM states are LOW, PEND_HI, HIGH, PEND_LO. run holds the count of qualifying samples so far.
  - LOW: strobe & above -> if DEBOUNCE=1, go to HIGH; else go to PEND_HI with run=1. Any other strobe stays in LOW.
  - PEND_HI: strobe & above -> run+1; when run+1 == DEBOUNCE, go to HIGH and run=0. Strobe & !above -> LOW, run=0.
  - HIGH and PEND_LO mirror LOW and PEND_HI, using below and the fall direction.
  - In LOW/PEND_HI, below is ignored; in HIGH/PEND_LO, above is ignored. Overlapping thresholds (thr_lo >= thr_hi) are therefore legal and carry no conflict.
- Latency: level, and the matching pulse, update on the clk edge that samples the DEBOUNCE-th qualifying strobe. Visible level = registered value one cycle after that strobe; this is the same cycle in which strobe_out for that sample is high.
- level=1 exactly in the HIGH and PEND_LO states.
- rise_pulse/fall_pulse are high for exactly one cycle per transition and are never both high.
- event_cnt:
  - Increments on each rise and saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt and a rise in the same cycle -> event_cnt=1.
  - clr_cnt alone -> 0.
- Thresholds may change at any time. New values apply from the next strobe; run is not reset by a threshold change.
- Back-to-back strobes (every cycle) are supported; each counts as a separate sample.
- sample_out/strobe_out are a pure one-cycle delay, independent of the FSM.

Test Plan:
- Reset then idle, rst pulsed high for 2 cycles -> all outputs 0; level stays 0 with no strobes.
- thr_hi=200, thr_lo=100, DEBOUNCE=3; strobe 0,0,255,255,255,255,0,0,0 with 1 idle cycle between strobes -> rise_pulse one cycle after the 5th sample; level=1; event_cnt=1. fall_pulse one cycle after the 9th sample; level=0.
- Glitch rejection: strobe 255,255,0,255,255 (thr_hi=200) -> no rise_pulse, level=0; a 6th sample 255 -> rise.
- Hysteresis: in HIGH, strobe 150 x5 (between thresholds) -> level stays 1; then 100 x3 -> fall at the 3rd sample, since thr_lo is inclusive.
- Saturation/clear, CNT_W=8: force 260 rise events -> event_cnt=255. Then clr_cnt in the same cycle as a rise -> event_cnt=1.
- Async reset mid-PEND_HI (after 2 of 3 qualifying samples) -> outputs 0 immediately. After release, 3 fresh qualifying samples are needed for a rise.
